decode_queue_ctrl: RTL and testbench
====================================

DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_if_valid, input, 1, fetch offers i_instr/i_pc this cycle.
REQ-004 SHALL have port o_if_ready, output, 1, queue accepts an offer this cycle.
REQ-005 SHALL have port i_instr, input, 32, fetched instruction word.
REQ-006 SHALL have port i_pc, input, 32, PC of i_instr.
REQ-007 SHALL have port o_id_valid, output, 1, head entry presented to execute.
REQ-008 SHALL have port i_ex_ready, input, 1, execute consumes the head entry this cycle.
REQ-009 SHALL have ports o_instr, input-width 32, and o_pc, 32, outputs carrying the head entry's instruction and PC.
REQ-010 SHALL have port o_imm, output, 32, sign-/zero-formed immediate of the head entry.
REQ-011 SHALL have port o_imm_type, output, 3, head format: 0 none, 1 I (I/LD/JR), 2 S, 3 B, 4 J, 5 U (U/UPC).
REQ-012 SHALL have port i_flush, input, 1, discard all queued entries.
REQ-013 SHALL have port o_illegal, output, 1, head opcode is unsupported (see Configuration).

Function
REQ-014 SHALL be a 2-entry in-order queue; occupancy states EMPTY, ONE, FULL.
REQ-015 Push SHALL occur when i_if_valid and o_if_ready; pop SHALL occur when o_id_valid and i_ex_ready.
REQ-016 o_if_ready SHALL be registered and equal (occupancy != FULL); it SHALL NOT depend combinationally on i_ex_ready.
REQ-017 o_id_valid SHALL equal (occupancy != EMPTY); an entry pushed in cycle N SHALL be visible at the head in cycle N+1 (latency 1).
REQ-018 Transitions: EMPTY+push->ONE; ONE+push-only->FULL; ONE+pop-only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-019 Immediate SHALL be computed at push time from opcode i_instr[6:0] and stored per entry: I/LD(0000011)/I(0010011)/JR(1100111) = sext(instr[31:20]); S(0100011) = sext({instr[31:25],instr[11:7]}); B(1100011) = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); J(1101111) = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); U(0110111)/UPC(0010111) = {instr[31:12],12'h000}; all other opcodes = 0, type 0.
REQ-020 Head outputs SHALL hold stable while o_id_valid=1 and i_ex_ready=0.
REQ-021 i_flush SHALL force occupancy EMPTY next cycle, overriding any same-cycle push and pop; the flushed offer is dropped, o_if_ready=1 next cycle.
REQ-022 When EMPTY, o_instr, o_pc, o_imm, o_imm_type, o_illegal SHALL read 0.
REQ-023 Entry order SHALL be preserved across a wrap of the internal read/write pointers.

Reset
REQ-024 During rst_n=0: occupancy EMPTY, pointers 0, o_id_valid=0, o_if_ready=0, all data outputs 0.
REQ-025 o_if_ready SHALL rise in the first clock edge after rst_n deasserts; reset mid-operation SHALL discard all entries.

Configuration
REQ-026 Macro ILLEGAL_OPCODE_EN defined: o_illegal SHALL be 1 for a head whose opcode is not among the eight listed nor R (0110011), FENCE (0001111), SYSTEM (1110011); flag stored per entry.
REQ-027 Macro ILLEGAL_OPCODE_EN undefined: o_illegal SHALL be tied 0 and no per-entry flag storage synthesized.

Verification
REQ-028 Push 0x00A00093 (addi) with i_ex_ready=1 -> next cycle o_id_valid=1, o_imm=0x0000000A, o_imm_type=1; popped, then EMPTY.
REQ-029 Push 0xFE000EE3 (beq -4) then 0x123452B7 (lui) with i_ex_ready=0 -> FULL, o_if_ready=0, head o_imm=0xFFFFFFFC type 3; after pop head o_imm=0x12345000 type 5.
REQ-030 Steady push+pop each cycle for 10 instructions -> occupancy stays ONE, in-order outputs, no bubbles.
REQ-031 FULL with i_flush=1 and simultaneous push+pop -> next cycle EMPTY, o_id_valid=0, o_if_ready=1, outputs 0.
REQ-032 Push 0x0000007F with ILLEGAL_OPCODE_EN -> o_illegal=1, o_imm=0; without macro o_illegal=0.
REQ-033 Assert rst_n=0 while FULL -> o_id_valid=0 immediately (async); first edge after release o_if_ready=1.

Source files
------------

// File: rtl/decode_queue_ctrl.sv
// decode_queue_ctrl
// Two-entry in-order queue between fetch and execute.
// Each entry holds the instruction, its PC, and an immediate plus format
// code that are decoded when the entry is pushed.
// Optional build macro: ILLEGAL_OPCODE_EN.
//   Defined:   each entry also stores a flag for an unsupported opcode,
//              and that flag drives o_illegal.
//   Undefined: o_illegal is tied low and no flag storage exists.
module decode_queue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_valid,
  output logic        o_if_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_id_valid,
  input  logic        i_ex_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_imm,
  output logic [2:0]  o_imm_type,
  input  logic        i_flush,
  output logic        o_illegal
);

  localparam int DEPTH = 2;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        wr_ptr_reg;
  logic        wr_ptr_next;
  logic        rd_ptr_reg;
  logic        rd_ptr_next;
  logic        if_ready_reg;

  logic        push;
  logic        pop;
  logic        valid;

  logic [31:0] dec_imm;
  logic [2:0]  dec_type;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] imm_mem   [DEPTH];
  logic [2:0]  type_mem  [DEPTH];
  logic [DEPTH-1:0] entry_we;

  logic        head_illegal;

  // The ready flag is registered, so push never depends on i_ex_ready in the same cycle.
  assign valid = (state_reg != ST_EMPTY);
  assign push  = i_if_valid & if_ready_reg;
  assign pop   = valid & i_ex_ready;

  // Decode the offered instruction's immediate and format code before it is stored.
  always_comb begin
    dec_imm  = '0;
    dec_type = IMM_NONE;
    case (i_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
        dec_type = IMM_I;
      end
      OP_STORE: begin
        dec_imm  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        dec_type = IMM_S;
      end
      OP_BRANCH: begin
        dec_imm  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
        dec_type = IMM_B;
      end
      OP_JAL: begin
        dec_imm  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};
        dec_type = IMM_J;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm  = {i_instr[31:12], 12'h000};
        dec_type = IMM_U;
      end
      default: begin
        dec_imm  = '0;
        dec_type = IMM_NONE;
      end
    endcase
  end

  // Flush suppresses the write, so a dropped offer never lands in storage.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_we[gi] = push & ~i_flush & (wr_ptr_reg == 1'(gi));

      // Capture the pushed entry into its slot; the payload needs no reset.
      always_ff @(posedge clk) begin
        if (entry_we[gi]) begin
          instr_mem[gi] <= i_instr;
          pc_mem[gi]    <= i_pc;
          imm_mem[gi]   <= dec_imm;
          type_mem[gi]  <= dec_type;
        end
      end
    end
  endgenerate

`ifdef ILLEGAL_OPCODE_EN
  logic             dec_illegal;
  logic [DEPTH-1:0] illegal_mem;

  // Flag any opcode outside the supported set.
  always_comb begin
    dec_illegal = 1'b1;
    case (i_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC,
      7'b0110011, 7'b0001111, 7'b1110011: dec_illegal = 1'b0;
      default:                            dec_illegal = 1'b1;
    endcase
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_illegal
    // Store the illegal flag next to the rest of the entry.
    always_ff @(posedge clk) begin
      if (entry_we[gi]) begin
        illegal_mem[gi] <= dec_illegal;
      end
    end
  end

  assign head_illegal = illegal_mem[rd_ptr_reg];
`else
  assign head_illegal = 1'b0;
`endif

  // State register: occupancy, pointers and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      if_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      if_ready_reg <= (state_next != ST_FULL);
    end
  end

  // Next state: a flush overrides any same-cycle push and pop.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (i_flush) begin
      state_next  = ST_EMPTY;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      case (state_reg)
        ST_EMPTY: if (push) state_next = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_next = ST_FULL;
          else if (pop && !push) state_next = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Outputs: present the head entry, and force the outputs to zero when the queue is empty.
  always_comb begin
    o_if_ready = if_ready_reg;
    o_id_valid = valid;
    o_instr    = '0;
    o_pc       = '0;
    o_imm      = '0;
    o_imm_type = IMM_NONE;
    o_illegal  = 1'b0;
    if (valid) begin
      o_instr    = instr_mem[rd_ptr_reg];
      o_pc       = pc_mem[rd_ptr_reg];
      o_imm      = imm_mem[rd_ptr_reg];
      o_imm_type = type_mem[rd_ptr_reg];
      o_illegal  = head_illegal;
    end
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed testbench for decode_queue_ctrl; expected values are hand-derived.
module tb_decode_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_valid;
  logic        o_if_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        o_id_valid;
  logic        i_ex_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_imm;
  logic [2:0]  o_imm_type;
  logic        i_flush;
  logic        o_illegal;

  int tests = 0;
  int fails = 0;

  decode_queue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_valid (i_if_valid),
    .o_if_ready (o_if_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .o_id_valid (o_id_valid),
    .i_ex_ready (i_ex_ready),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_imm      (o_imm),
    .o_imm_type (o_imm_type),
    .i_flush    (i_flush),
    .o_illegal  (o_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, {31'b0, o_id_valid}, 32'd0);
    check({tag, ".instr"}, o_instr, 32'd0);
    check({tag, ".pc"},    o_pc,    32'd0);
    check({tag, ".imm"},   o_imm,   32'd0);
    check({tag, ".type"},  {29'b0, o_imm_type}, 32'd0);
    check({tag, ".ill"},   {31'b0, o_illegal},  32'd0);
  endtask

  logic [31:0] exp_ill;
  logic [31:0] k_instr;

  initial begin
    rst_n = 1'b0; i_if_valid = 1'b0; i_instr = '0; i_pc = '0;
    i_ex_ready = 1'b0; i_flush = 1'b0;

    // Reset state
    step(); step();
    check("rst.ready", {31'b0, o_if_ready}, 32'd0);
    check_empty("rst");
    rst_n = 1'b1;
    step();
    check("rel.ready", {31'b0, o_if_ready}, 32'd1);
    check("rel.valid", {31'b0, o_id_valid}, 32'd0);
    $display("[TB] reset done");

    // addi x1,x0,10 pushed and popped
    i_if_valid = 1'b1; i_instr = 32'h00A00093; i_pc = 32'h100; i_ex_ready = 1'b1;
    step();
    i_if_valid = 1'b0;
    check("addi.valid", {31'b0, o_id_valid}, 32'd1);
    check("addi.instr", o_instr, 32'h00A00093);
    check("addi.pc",    o_pc,    32'h100);
    check("addi.imm",   o_imm,   32'h0000000A);
    check("addi.type",  {29'b0, o_imm_type}, 32'd1);
    step();
    check_empty("addi.pop");
    $display("[TB] addi push/pop");

    // beq -4 then lui while execute stalls
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_instr = 32'hFE000EE3; i_pc = 32'h200;
    step();
    i_instr = 32'h123452B7; i_pc = 32'h204;
    step();
    i_if_valid = 1'b0;
    check("full.ready", {31'b0, o_if_ready}, 32'd0);
    check("full.valid", {31'b0, o_id_valid}, 32'd1);
    check("beq.imm",    o_imm,  32'hFFFFFFFC);
    check("beq.type",   {29'b0, o_imm_type}, 32'd3);
    check("beq.pc",     o_pc,   32'h200);
    step();
    check("beq.hold.instr", o_instr, 32'hFE000EE3);
    check("beq.hold.imm",   o_imm,   32'hFFFFFFFC);
    i_ex_ready = 1'b1;
    step();
    check("lui.imm",   o_imm,  32'h12345000);
    check("lui.type",  {29'b0, o_imm_type}, 32'd5);
    check("lui.pc",    o_pc,   32'h204);
    check("lui.ready", {31'b0, o_if_ready}, 32'd1);
    step();
    check_empty("lui.pop");
    $display("[TB] beq/lui full and drain");

    // Streaming push+pop each cycle, wraps the pointers several times
    i_ex_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      k_instr = {20'(k + 1), 12'h0} | 32'h0000_0093;
      k_instr = {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
      i_if_valid = 1'b1; i_instr = k_instr; i_pc = 32'h1000 + 32'(4 * k);
      step();
      check("stream.instr", o_instr, k_instr);
      check("stream.imm",   o_imm,   32'(k));
      check("stream.pc",    o_pc,    32'h1000 + 32'(4 * k));
      check("stream.ready", {31'b0, o_if_ready}, 32'd1);
      $display("[TB] stream k=%0d instr=%h", k, o_instr);
    end
    i_if_valid = 1'b0;
    step();
    check_empty("stream.end");

    // Flush while full with an offer and a pop in the same cycle
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_instr = 32'h00500113; i_pc = 32'h300;
    step();
    i_instr = 32'h00600193; i_pc = 32'h304;
    step();
    check("pre_flush.ready", {31'b0, o_if_ready}, 32'd0);
    i_instr = 32'h00700213; i_pc = 32'h308;
    i_ex_ready = 1'b1; i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_if_valid = 1'b0;
    check("flush.ready", {31'b0, o_if_ready}, 32'd1);
    check_empty("flush");
    $display("[TB] flush from full");

    // Flush drops an offer accepted in the same cycle
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_instr = 32'h00800293; i_pc = 32'h400;
    step();
    i_instr = 32'h00900313; i_pc = 32'h404; i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_if_valid = 1'b0;
    check_empty("flush_one");
    check("flush_one.ready", {31'b0, o_if_ready}, 32'd1);
    $display("[TB] flush from one");

    // Unsupported opcode
`ifdef ILLEGAL_OPCODE_EN
    exp_ill = 32'd1;
`else
    exp_ill = 32'd0;
`endif
    i_if_valid = 1'b1; i_instr = 32'h0000007F; i_pc = 32'h500;
    step();
    i_instr = 32'h00000033; i_pc = 32'h504;
    step();
    i_if_valid = 1'b0;
    check("bad.ill",  {31'b0, o_illegal}, exp_ill);
    check("bad.imm",  o_imm, 32'd0);
    check("bad.type", {29'b0, o_imm_type}, 32'd0);
    i_ex_ready = 1'b1;
    step();
    check("r.ill",   {31'b0, o_illegal}, 32'd0);
    check("r.instr", o_instr, 32'h00000033);
    step();
    check_empty("bad.pop");
    $display("[TB] illegal opcode");

    // Asynchronous reset while full
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_instr = 32'h00A00093; i_pc = 32'h600;
    step();
    i_instr = 32'hFE000EE3; i_pc = 32'h604;
    step();
    i_if_valid = 1'b0;
    check("prereset.valid", {31'b0, o_id_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("areset.valid", {31'b0, o_id_valid}, 32'd0);
    check("areset.ready", {31'b0, o_if_ready}, 32'd0);
    check_empty("areset");
    step();
    rst_n = 1'b1;
    step();
    check("postreset.ready", {31'b0, o_if_ready}, 32'd1);
    check("postreset.valid", {31'b0, o_id_valid}, 32'd0);
    $display("[TB] async reset while full");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
